ascii_tx_arbiter: RTL and testbench

ASCII_TX_ARBITER -- requirements
Module: ascii_tx_arbiter

---
 rtl/ascii_arb_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/ascii_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_ascii_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_arb_pkg.sv
// Shared types and constants for the ASCII transmit arbiter.
// ASCII_ARB_SEP_EN adds the separator state to the state encoding.
package ascii_arb_pkg;

`ifdef ASCII_ARB_SEP_EN
  typedef enum logic [1:0] {StIdle, StGrant, StSep} arb_state_e;
`else
  typedef enum logic [0:0] {StIdle, StGrant} arb_state_e;
`endif

  localparam logic [7:0] SEP_CHAR = 8'h0A;
  localparam int unsigned TMO_WIDTH = 17;

  // Source index width, never narrower than one bit.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first asserted request searching upward from
// last_grant+1, wrapping from NUM_SRC-1 to 0.
module rr_priority_picker #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_req
);

  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      idx = ID_WIDTH'((int'(last_grant) + int'(i)) % int'(NUM_SRC));
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/ascii_tx_arbiter.sv
// Arbitrates packetised ASCII byte streams from NUM_SRC sources onto one UART
// transmit port. Optional macro ASCII_ARB_SEP_EN appends a newline per packet.
module ascii_tx_arbiter
  import ascii_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned ID_WIDTH      = id_width(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*8-1:0]  src_data,
  input  logic [NUM_SRC-1:0]    src_last,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic [7:0]            ascii_data,
  output logic                  ascii_valid,
  input  logic                  ascii_ready,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT_CYCLES);

  arb_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  last_q, last_d;
  logic [TMO_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic [ID_WIDTH-1:0]  winner;
  logic                 any_req;
  logic                 valid_g, last_g;
  logic [7:0]           data_g;

  rr_priority_picker #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req        (src_valid),
    .last_grant (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Mux of the granted source's byte stream.
  always_comb begin
    valid_g = 1'b0;
    last_g  = 1'b0;
    data_g  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        valid_g = src_valid[i];
        last_g  = src_last[i];
        data_g  = src_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    ascii_valid = 1'b0;
    ascii_data  = '0;
    src_ready   = '0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (any_req) begin
          grant_d = winner;
          state_d = StGrant;
        end
      end

      StGrant: begin
        ascii_valid = valid_g;
        ascii_data  = data_g;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          src_ready[i] = ascii_ready && (grant_q == ID_WIDTH'(i));
        end
        if (valid_g) begin
          cnt_d = '0;
          if (ascii_ready && last_g) begin
            last_d = grant_q;
`ifdef ASCII_ARB_SEP_EN
            state_d = StSep;
`else
            state_d = StIdle;
`endif
          end
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Stalled source: release the lock without a separator.
          if ((TIMEOUT_CYCLES != 0) && (cnt_d >= TMO_LIMIT)) begin
            tmo_d   = 1'b1;
            last_d  = grant_q;
            state_d = StIdle;
          end
        end
      end

`ifdef ASCII_ARB_SEP_EN
      StSep: begin
        ascii_valid = 1'b1;
        ascii_data  = SEP_CHAR;
        if (ascii_ready) begin
          state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(NUM_SRC - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ascii_tx_arbiter.sv
// Directed self-checking bench for ascii_tx_arbiter (NUM_SRC=4, TIMEOUT_CYCLES=10).
// Expected streams include the newline separator only when ASCII_ARB_SEP_EN is defined.
module tb_ascii_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_last;
  logic [3:0]  src_ready;
  logic [7:0]  ascii_data;
  logic        ascii_valid;
  logic        ascii_ready = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  ascii_tx_arbiter #(
    .NUM_SRC        (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-source FIFO of {last, byte}; pops when the DUT accepted at the edge.
  logic [8:0] smem [4][16];
  int         shead [4] = '{default: 0};
  int         stail [4] = '{default: 0};
  logic [3:0] pop_mask = '0;

  logic [9:0] mon_q [$];
  logic [9:0] exp_q [$];
  int         mon_base = 0;

  function automatic void drive_srcs();
    for (int i = 0; i < 4; i++) begin
      if (shead[i] != stail[i]) begin
        src_valid[i]        = 1'b1;
        src_last[i]         = smem[i][shead[i] % 16][8];
        src_data[8*i +: 8]  = smem[i][shead[i] % 16][7:0];
      end else begin
        src_valid[i]        = 1'b0;
        src_last[i]         = 1'b0;
        src_data[8*i +: 8]  = 8'h00;
      end
    end
  endfunction

  initial begin
    drive_srcs();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (pop_mask[i] === 1'b1 && shead[i] != stail[i]) shead[i] = shead[i] + 1;
      end
      drive_srcs();
    end
  end

  always @(negedge clk) begin
    pop_mask = src_ready & src_valid;
    if (rst_n && ascii_valid && ascii_ready) mon_q.push_back({grant_id, ascii_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int s, input logic [7:0] b, input logic l);
    smem[s][stail[s] % 16] = {l, b};
    stail[s] = stail[s] + 1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) stail[i] = shead[i];
  endtask

  task automatic exp_byte(input logic [1:0] id, input logic [7:0] b);
    exp_q.push_back({id, b});
  endtask

  task automatic exp_end(input logic [1:0] id);
`ifdef ASCII_ARB_SEP_EN
    exp_q.push_back({id, 8'h0A});
`endif
  endtask

  task automatic check_stream(input string tag);
    int got_n;
    got_n = mon_q.size() - mon_base;
    check_eq($sformatf("%s_count", tag), got_n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      check_eq($sformatf("%s_xfer%0d", tag, i), {22'd0, mon_q[mon_base + i]}, {22'd0, exp_q[i]});
    end
    mon_base = mon_q.size();
    exp_q.delete();
  endtask

  task automatic wait_busy(input string tag);
    for (int k = 0; k < 8 && !busy; k++) step();
    check_eq(tag, busy, 1);
  endtask

  task automatic do_reset();
    ascii_ready = 1'b0;
    rst_n = 1'b0;
    flush();
    step(2);
    rst_n = 1'b1;
    step();
    mon_base = mon_q.size();
  endtask

  initial begin
    // Reset state
    step(2);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant_id, 0);
    check_eq("rst_valid", ascii_valid, 0);
    check_eq("rst_data", ascii_data, 0);
    check_eq("rst_ready", src_ready, 0);
    check_eq("rst_tmo", timeout_err, 0);
    rst_n = 1'b1;
    step();

    // Single source: src 2 sends "AB"
    ascii_ready = 1'b1;
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b1);
    step(12);
    exp_byte(2, 8'h41);
    exp_byte(2, 8'h42);
    exp_end(2);
    check_stream("single");
    check_eq("single_grant", grant_id, 2);
    check_eq("single_busy", busy, 0);

    // Round-robin from reset: 0,1,3 then src 0's second packet
    do_reset();
    ascii_ready = 1'b1;
    push(0, 8'h61, 1'b1);
    push(0, 8'h65, 1'b1);
    push(1, 8'h62, 1'b1);
    push(3, 8'h64, 1'b1);
    step(20);
    exp_byte(0, 8'h61); exp_end(0);
    exp_byte(1, 8'h62); exp_end(1);
    exp_byte(3, 8'h64); exp_end(3);
    exp_byte(0, 8'h65); exp_end(0);
    check_stream("rr");

    // Lock and backpressure: src 1 packet, src 0 requests mid-packet
    ascii_ready = 1'b0;
    push(1, 8'h31, 1'b0);
    push(1, 8'h33, 1'b0);
    push(1, 8'h35, 1'b1);
    wait_busy("lock_busy");
    check_eq("lock_grant", grant_id, 1);
    check_eq("lock_first", ascii_data, 8'h31);
    push(0, 8'h7A, 1'b1);
    ascii_ready = 1'b1;
    step();
    ascii_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("bp_data%0d", k), ascii_data, 8'h33);
      check_eq($sformatf("bp_valid%0d", k), ascii_valid, 1);
      check_eq($sformatf("bp_ready%0d", k), src_ready, 4'b0000);
      check_eq($sformatf("lock_grant%0d", k), grant_id, 1);
      step();
    end
    ascii_ready = 1'b1;
    step(12);
    exp_byte(1, 8'h31);
    exp_byte(1, 8'h33);
    exp_byte(1, 8'h35); exp_end(1);
    exp_byte(0, 8'h7A); exp_end(0);
    check_stream("lock");

    // Timeout: src 2 sends one non-final byte then goes quiet
    push(2, 8'h54, 1'b0);
    wait_busy("tmo_busy");
    check_eq("tmo_grant", grant_id, 2);
    step();
    for (int k = 1; k <= 10; k++) begin
      check_eq($sformatf("tmo_wait_busy%0d", k), busy, 1);
      check_eq($sformatf("tmo_wait_err%0d", k), timeout_err, 0);
      step();
    end
    check_eq("tmo_pulse", timeout_err, 1);
    check_eq("tmo_idle", busy, 0);
    step();
    check_eq("tmo_pulse_end", timeout_err, 0);
    step(3);
    exp_byte(2, 8'h54);
    check_stream("tmo");

    // Reset mid-packet, then source 0 has priority again
    ascii_ready = 1'b0;
    push(3, 8'h51, 1'b0);
    push(3, 8'h52, 1'b1);
    wait_busy("mid_busy");
    check_eq("mid_grant", grant_id, 3);
    check_eq("mid_valid", ascii_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", ascii_valid, 0);
    check_eq("arst_data", ascii_data, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_grant", grant_id, 0);
    check_eq("arst_ready", src_ready, 0);
    flush();
    step(2);
    rst_n = 1'b1;
    step();
    ascii_ready = 1'b1;
    push(1, 8'h71, 1'b1);
    push(0, 8'h70, 1'b1);
    step(12);
    exp_byte(0, 8'h70); exp_end(0);
    exp_byte(1, 8'h71); exp_end(1);
    check_stream("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
